// File: rtl/dac_sample_scheduler.sv
// Sample FIFO and strobe sequencer for the CIC-interpolated sigma-delta DAC path.
// Primes the FIFO, then emits int_ena / comb_ena and pops one sample per comb_ena.
module dac_sample_scheduler #(
  parameter int unsigned BITLEN     = 16,
  parameter int unsigned OSR        = 1024,
  parameter int unsigned INT_DIV    = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PRIME_LVL  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [BITLEN-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [BITLEN-1:0]             cic_data,
  output logic                          comb_ena,
  output logic                          int_ena,
  output logic                          running,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          underrun_clr
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned LW1 = LW + 1;
  localparam int unsigned DW  = (INT_DIV > 1) ? $clog2(INT_DIV) : 1;
  localparam int unsigned PW  = $clog2(OSR);

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e            state_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic [DW-1:0]     div_q, div_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [BITLEN-1:0] cic_data_q;
  logic              int_ena_q, comb_ena_q, underrun_q;
  logic [BITLEN-1:0] mem [FIFO_DEPTH];

  logic push, primed, run_next, int_d, comb_d, pop_hit, pop_miss;

  assign s_ready  = (state_q != StIdle) && (level_q != LW'(FIFO_DEPTH));
  assign push     = s_valid && s_ready;
  assign primed   = ({1'b0, level_q} + LW1'(push)) >= LW1'(PRIME_LVL);
  assign run_next = ena && ((state_q == StRun) || ((state_q == StPrime) && primed));

  // Counters describe the cycle about to start; both restart from zero on RUN entry.
  always_comb begin
    div_d   = '0;
    phase_d = '0;
    if (state_q == StRun) begin
      div_d   = (div_q == DW'(INT_DIV - 1)) ? '0 : div_q + DW'(1);
      phase_d = int_ena_q ? phase_q + PW'(1) : phase_q;
    end
  end

  assign int_d    = run_next && (div_d == DW'(INT_DIV - 1));
  assign comb_d   = int_d && (phase_d == '0);
  assign pop_hit  = comb_d && (level_q != '0);
  assign pop_miss = comb_d && (level_q == '0);

  always_comb begin
    level_d = level_q;
    case ({push, pop_hit})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      div_q      <= '0;
      phase_q    <= '0;
      cic_data_q <= '0;
      int_ena_q  <= 1'b0;
      comb_ena_q <= 1'b0;
      underrun_q <= 1'b0;
    end else if (!ena) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      div_q      <= '0;
      phase_q    <= '0;
      cic_data_q <= '0;
      int_ena_q  <= 1'b0;
      comb_ena_q <= 1'b0;
      underrun_q <= underrun_q & ~underrun_clr;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= StPrime;
        StPrime: if (primed) state_q <= StRun;
        StRun:   state_q <= StRun;
        default: state_q <= StIdle;
      endcase
      div_q      <= div_d;
      phase_q    <= phase_d;
      int_ena_q  <= int_d;
      comb_ena_q <= comb_d;
      level_q    <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_hit) begin
        cic_data_q <= mem[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + AW'(1);
      end
      if (pop_miss)          underrun_q <= 1'b1;
      else if (underrun_clr) underrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  assign cic_data   = cic_data_q;
  assign comb_ena   = comb_ena_q;
  assign int_ena    = int_ena_q;
  assign running    = (state_q == StRun);
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Bench for dac_sample_scheduler: queue-based reference model checked every cycle on
// instance A, plus directed literal checks on A and on a PRIME_LVL=4 instance B.
module tb_dac_sample_scheduler;

  localparam int OSR_T = 4;
  localparam int DIV_T = 2;
  localparam int DEP_T = 4;
  localparam int PRI_T = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena, s_valid, underrun_clr;
  logic [15:0] s_data;
  logic        s_ready, comb_ena, int_ena, running, underrun;
  logic [15:0] cic_data;
  logic [2:0]  fifo_level;

  logic        ena_b, s_valid_b;
  logic [15:0] s_data_b;
  logic        s_ready_b, comb_ena_b, int_ena_b, running_b, underrun_b;
  logic [15:0] cic_data_b;
  logic [2:0]  fifo_level_b;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  dac_sample_scheduler #(
    .BITLEN(16), .OSR(OSR_T), .INT_DIV(DIV_T), .FIFO_DEPTH(DEP_T), .PRIME_LVL(PRI_T)
  ) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cic_data(cic_data), .comb_ena(comb_ena), .int_ena(int_ena), .running(running),
    .fifo_level(fifo_level), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  dac_sample_scheduler #(
    .BITLEN(16), .OSR(OSR_T), .INT_DIV(DIV_T), .FIFO_DEPTH(DEP_T), .PRIME_LVL(4)
  ) dut_b (
    .clk(clk), .rst(rst), .ena(ena_b), .s_data(s_data_b), .s_valid(s_valid_b),
    .s_ready(s_ready_b), .cic_data(cic_data_b), .comb_ena(comb_ena_b), .int_ena(int_ena_b),
    .running(running_b), .fifo_level(fifo_level_b), .underrun(underrun_b),
    .underrun_clr(1'b0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model for instance A: mode 0=idle 1=prime 2=run, run_cyc = RUN cycle number.
  logic [15:0] q[$];
  int          m_mode, run_cyc;
  bit          m_push, m_set;
  logic [15:0] e_cic;
  bit          e_int, e_comb, e_und, e_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_mode = 0; run_cyc = 0; e_cic = '0;
      e_int = 0; e_comb = 0; e_und = 0; e_ready = 0;
    end else begin
      m_push = s_valid && e_ready;
      if (!ena) begin
        q.delete();
        m_mode = 0; run_cyc = 0; e_cic = '0; e_int = 0; e_comb = 0;
        if (underrun_clr) e_und = 0;
      end else begin
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && (q.size() + (m_push ? 1 : 0)) >= PRI_T) begin
          m_mode = 2; run_cyc = 0;
        end
        if (m_mode == 2) begin
          run_cyc++;
          e_int  = (run_cyc % DIV_T) == 0;
          e_comb = e_int && (((run_cyc / DIV_T) - 1) % OSR_T) == 0;
        end else begin
          e_int = 0; e_comb = 0;
        end
        m_set = 0;
        if (e_comb) begin
          if (q.size() > 0) e_cic = q.pop_front();
          else m_set = 1;
        end
        if (m_push) q.push_back(s_data);
        if (m_set) e_und = 1;
        else if (underrun_clr) e_und = 0;
      end
      e_ready = (m_mode != 0) && (q.size() < DEP_T);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_s_ready",  32'(s_ready),    32'(e_ready));
      chk("m_cic_data", 32'(cic_data),   32'(e_cic));
      chk("m_comb_ena", 32'(comb_ena),   32'(e_comb));
      chk("m_int_ena",  32'(int_ena),    32'(e_int));
      chk("m_running",  32'(running),    32'(m_mode == 2));
      chk("m_level",    32'(fifo_level), 32'(q.size()));
      chk("m_underrun", 32'(underrun),   32'(e_und));
    end
  end

  initial begin
    rst = 1'b1; ena = 1'b0; s_valid = 1'b0; s_data = '0; underrun_clr = 1'b0;
    ena_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_running", 32'(running), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_cic", 32'(cic_data), 0);
    @(negedge clk);
    chk("idle_ready", 32'(s_ready), 0);
    ena = 1'b1;

    // Prime with two samples, then run through the first three input-rate strobes.
    @(negedge clk);
    chk("prime_ready", 32'(s_ready), 1);
    s_valid = 1'b1; s_data = 16'h1111;
    @(negedge clk);
    chk("prime_lvl1", 32'(fifo_level), 1);
    chk("prime_not_run", 32'(running), 0);
    s_data = 16'h2222;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) begin
        s_valid = 1'b0;
        chk("run_c1", 32'(running), 1);
        chk("run_c1_lvl", 32'(fifo_level), 2);
      end
      chk("int_pat", 32'(int_ena), 32'((c % 2) == 0));
      chk("comb_pat", 32'(comb_ena), 32'(c == 2 || c == 10 || c == 18));
      if (c == 2) begin
        chk("cic_c2", 32'(cic_data), 32'h1111);
        chk("lvl_c2", 32'(fifo_level), 1);
      end
      if (c == 10) begin
        chk("cic_c10", 32'(cic_data), 32'h2222);
        chk("lvl_c10", 32'(fifo_level), 0);
      end
      if (c == 17) chk("und_pre", 32'(underrun), 0);
      if (c == 18) begin
        chk("und_set_vs_clr", 32'(underrun), 1);
        chk("und_cic_hold", 32'(cic_data), 32'h2222);
      end
      if (c == 19) chk("und_clr", 32'(underrun), 0);
      underrun_clr = (c == 17 || c == 18);
    end

    // Disable mid-RUN just before an int_ena cycle, then re-prime.
    ena = 1'b0;
    @(negedge clk);
    chk("dis_int", 32'(int_ena), 0);
    chk("dis_run", 32'(running), 0);
    chk("dis_lvl", 32'(fifo_level), 0);
    chk("dis_cic", 32'(cic_data), 0);
    ena = 1'b1;
    @(negedge clk);
    s_valid = 1'b1; s_data = 16'h3333;
    @(negedge clk);
    s_data = 16'h4444;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) s_valid = 1'b0;
      if (c == 2) begin
        chk("re_cic_c2", 32'(cic_data), 32'h3333);
        chk("re_lvl_c2", 32'(fifo_level), 1);
      end
      if (c == 9) begin s_valid = 1'b1; s_data = 16'h5555; end
      if (c == 10) begin
        s_valid = 1'b0;
        chk("pp_comb", 32'(comb_ena), 1);
        chk("pp_cic", 32'(cic_data), 32'h4444);
        chk("pp_lvl", 32'(fifo_level), 1);
      end
      if (c == 18) begin
        chk("pp_cic2", 32'(cic_data), 32'h5555);
        chk("pp_lvl2", 32'(fifo_level), 0);
        s_valid = 1'b1; s_data = 16'h6666;
      end
      if (c == 19) s_data = 16'h7777;
      if (c == 20) s_data = 16'h8888;
      if (c == 21) s_valid = 1'b0;
    end

    // Cycle 22 has int_ena high and level 3: asynchronous reset clears outputs at once.
    chk("pre_rst_lvl", 32'(fifo_level), 3);
    chk("pre_rst_int", 32'(int_ena), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_int", 32'(int_ena), 0);
    chk("arst_run", 32'(running), 0);
    chk("arst_cic", 32'(cic_data), 0);
    chk("arst_ready", 32'(s_ready), 0);
    ena = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(s_ready), 0);
    chk("post_rst_run", 32'(running), 0);

    // Instance B: four pushes fill the FIFO before any strobe; fifth is held off.
    ena_b = 1'b1;
    @(negedge clk);
    s_valid_b = 1'b1; s_data_b = 16'hA000;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      s_data_b = 16'hA000 + 16'(i);
    end
    chk("b_prime_lvl3", 32'(fifo_level_b), 3);
    chk("b_prime_run", 32'(running_b), 0);
    @(negedge clk);
    s_data_b = 16'hA004;
    chk("b_full_lvl", 32'(fifo_level_b), 4);
    chk("b_full_ready", 32'(s_ready_b), 0);
    chk("b_full_int", 32'(int_ena_b), 0);
    chk("b_full_comb", 32'(comb_ena_b), 0);
    @(negedge clk);
    s_valid_b = 1'b0;
    chk("b_pop_lvl", 32'(fifo_level_b), 3);
    chk("b_pop_cic", 32'(cic_data_b), 32'hA000);
    chk("b_pop_comb", 32'(comb_ena_b), 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
